// File: rtl/jk_driver_if.sv
// jk_driver_if: J/K drive and Q/Qbar return between the driver and the flop under test
interface jk_driver_if;
  logic j, k, q, qbar;
  modport master (output j, k, input q, qbar);
  modport slave (input j, k, output q, qbar);
endinterface

// File: rtl/jk_driver.sv
// jk_driver: self-checking JK code sequencer with reference model and saturating error count
module jk_driver #(
  parameter int STEP_CYCLES = 4,
  parameter int N_REPEAT = 2,
  parameter int ERR_W = 8
) (
  input  logic clk,
  input  logic clrn,
  input  logic start,
  jk_driver_if.master jk,
  output logic busy,
  output logic done,
  output logic [ERR_W-1:0] err_cnt
);
  localparam int SW = STEP_CYCLES > 1 ? $clog2(STEP_CYCLES) : 1;
  localparam int PW = N_REPEAT > 1 ? $clog2(N_REPEAT) : 1;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t state, state_n;
  logic [SW-1:0] step, step_n;
  logic [1:0] code, code_n;
  logic [PW-1:0] pass, pass_n;
  logic j, k, exp_q, last_step, wrap, miss;
  assign jk.j = j;
  assign jk.k = k;
  assign last_step = step == SW'(STEP_CYCLES - 1);
  assign wrap = last_step && code == 2'd3;
  // DONE is checked too: it observes the effect of the final code
  assign miss = state != IDLE && (jk.q != exp_q || jk.qbar == jk.q);
  always_comb begin
    state_n = state;
    step_n = '0;
    code_n = '0;
    pass_n = '0;
    if (state == IDLE) state_n = start ? RUN : IDLE;
    else if (state == DONE) state_n = IDLE;
    else begin
      step_n = last_step ? '0 : step + 1'b1;
      code_n = last_step ? code + 1'b1 : code;
      pass_n = wrap ? pass + 1'b1 : pass;
      if (wrap && pass == PW'(N_REPEAT - 1)) begin
        state_n = DONE;
        pass_n = '0;
      end
    end
  end
  always_ff @(posedge clk or negedge clrn)
    if (!clrn) begin
      state <= IDLE;
      step <= '0;
      code <= '0;
      pass <= '0;
      j <= 1'b0;
      k <= 1'b0;
      busy <= 1'b0;
      done <= 1'b0;
      exp_q <= 1'b0;
      err_cnt <= '0;
    end else begin
      state <= state_n;
      step <= step_n;
      code <= code_n;
      pass <= pass_n;
      j <= state_n == RUN && code_n[0];
      k <= state_n == RUN && code_n[1];
      busy <= state_n == RUN;
      done <= state_n == DONE;
      exp_q <= j && k ? ~exp_q : j | (~k & exp_q);
      err_cnt <= state == IDLE && start ? '0 : miss && err_cnt != '1 ? err_cnt + 1'b1 : err_cnt;
    end
endmodule

// File: tb/tb_jk_driver.sv
// tb_jk_driver: directed checks of jk_driver against behavioural and faulty JK flops
module tb_jk_driver;
  logic clk = 1'b0, clrn = 1'b0;
  logic start0 = 1'b0, start1 = 1'b0, start2 = 1'b0;
  logic busy0, done0, busy1, done1, busy2, done2;
  logic [7:0] err0, err2;
  logic [2:0] err1;
  logic f0, f2;
  int mode = 0;
  int n_cmp = 0, n_bad = 0;
  jk_driver_if b0 ();
  jk_driver_if b1 ();
  jk_driver_if b2 ();
  jk_driver d0 (.clk(clk), .clrn(clrn), .start(start0), .jk(b0), .busy(busy0), .done(done0), .err_cnt(err0));
  jk_driver #(.ERR_W(3)) d1 (.clk(clk), .clrn(clrn), .start(start1), .jk(b1), .busy(busy1), .done(done1), .err_cnt(err1));
  jk_driver #(.STEP_CYCLES(1), .N_REPEAT(1)) d2 (.clk(clk), .clrn(clrn), .start(start2), .jk(b2), .busy(busy2), .done(done2), .err_cnt(err2));
  always #5 clk = ~clk;
  always_ff @(posedge clk or negedge clrn)
    if (!clrn) f0 <= 1'b0;
    else f0 <= b0.j && b0.k ? ~f0 : b0.j ? 1'b1 : b0.k ? 1'b0 : f0;
  always_ff @(posedge clk or negedge clrn)
    if (!clrn) f2 <= 1'b0;
    else f2 <= b2.j && b2.k ? ~f2 : b2.j ? 1'b1 : b2.k ? 1'b0 : f2;
  assign b0.q = mode == 1 ? 1'b0 : f0;
  assign b0.qbar = mode == 2 ? b0.q : ~b0.q;
  assign b1.q = 1'b0;
  assign b1.qbar = 1'b1;
  assign b2.q = f2;
  assign b2.qbar = ~f2;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [1:0] code_jk(input int c);
    return c == 1 ? 2'b10 : c == 2 ? 2'b01 : c == 3 ? 2'b11 : 2'b00;
  endfunction

  task automatic run_chk(input string tag, input int exp_err);
    logic [3:0] e;
    @(negedge clk) start0 = 1'b1;
    @(negedge clk) start0 = 1'b0;
    for (int i = 0; i < 34; i++) begin
      e = i < 32 ? {2'b10, code_jk((i / 4) % 4)} : i == 32 ? 4'b0100 : 4'b0000;
      check($sformatf("%s_bdjk[%0d]", tag, i), {busy0, done0, b0.j, b0.k}, e);
      @(negedge clk);
    end
    repeat (3) @(negedge clk);
    check({tag, "_err"}, err0, exp_err);
  endtask

  initial begin
    @(negedge clk);
    check("reset", {busy0, done0, b0.j, b0.k, err0}, 0);
    clrn = 1'b1;
    repeat (4) @(negedge clk);
    run_chk("ideal", 0);
    mode = 1;
    run_chk("stuck0", 12);
    mode = 2;
    run_chk("qbar_eq_q", 33);
    mode = 0;
    @(negedge clk) start1 = 1'b1;
    @(negedge clk) start1 = 1'b0;
    repeat (40) @(negedge clk);
    check("sat_err_w3", err1, 7);
    mode = 1;
    @(negedge clk) start0 = 1'b1;
    @(negedge clk) start0 = 1'b0;
    repeat (10) @(negedge clk);
    check("pre_abort_err", err0, 4);
    check("pre_abort_busy", busy0, 1);
    clrn = 1'b0;
    #1 check("abort_zero", {busy0, done0, b0.j, b0.k, err0}, 0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check($sformatf("abort_hold[%0d]", i), {busy0, done0, b0.j, b0.k, err0}, 0);
    end
    clrn = 1'b1;
    mode = 0;
    repeat (2) @(negedge clk);
    check("post_abort_idle", {busy0, done0}, 0);
    run_chk("post_abort", 0);
    @(negedge clk) start2 = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 18; i++) begin
      int p;
      p = i % 6;
      check($sformatf("held_start[%0d]", i), {busy2, done2, b2.j, b2.k}, p < 4 ? {2'b10, code_jk(p)} : p == 4 ? 4'b0100 : 4'b0000);
      @(negedge clk);
    end
    start2 = 1'b0;
    check("held_start_err", err2, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
